// File: rtl/psum_deskew_acc_if.sv
`default_nettype none
// ============================================================================
// Module : psum_deskew_acc_if
// Desc   : Bundle of the job-control, skewed partial-sum input and drain
//          handshake signals of psum_deskew_acc. master = array/controller
//          plus writeback side, slave = the deskew/accumulate block.
// Rev    : 1.0 - initial release
// ============================================================================
interface psum_deskew_acc_if #(
  parameter int ROWS        = 8,
  parameter int PSUM_BW     = 19,
  parameter int ACC_BW      = 32,
  parameter int TILE_CNT_BW = 8
);
  logic                     start;
  logic [TILE_CNT_BW-1:0]   num_tiles;
  logic [ROWS*PSUM_BW-1:0]  psum_in;
  logic                     in_valid;
  logic [ROWS*ACC_BW-1:0]   out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, num_tiles, psum_in, in_valid, out_ready,
    input  out_data, out_valid, busy, done, err
  );

  modport slave (
    input  start, num_tiles, psum_in, in_valid, out_ready,
    output out_data, out_valid, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/psum_deskew_acc.sv
`default_nettype none
// ============================================================================
// Module : psum_deskew_acc
// Desc   : Re-aligns the row-skewed partial sums leaving the last PE column,
//          accumulates whole vectors over K-tiles into a DEPTH x ROWS bank and
//          drains the bank over a valid/ready handshake.
// Config : SATURATE_EN - when defined, accumulator adds clamp to the signed
//          ACC_BW range; otherwise they wrap modulo 2^ACC_BW.
// Rev    : 1.0 - initial release
// ============================================================================
module psum_deskew_acc #(
  parameter int ROWS        = 8,
  parameter int PSUM_BW     = 19,
  parameter int ACC_BW      = 32,
  parameter int DEPTH       = 8,
  parameter int TILE_CNT_BW = 8
) (
  input  logic              clk,
  input  logic              rst,
  psum_deskew_acc_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]       c_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]       c_PTR_ONE  = PTR_W'(1);
  localparam logic [TILE_CNT_BW-1:0] c_ONE_TILE = TILE_CNT_BW'(1);
`ifdef SATURATE_EN
  localparam logic [ACC_BW-1:0] c_ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
  localparam logic [ACC_BW-1:0] c_ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [TILE_CNT_BW-1:0]   r_tile_idx;
  logic [TILE_CNT_BW-1:0]   r_num_tiles;
  logic [ACC_BW-1:0]        r_acc [DEPTH][ROWS];
  logic [ROWS*ACC_BW-1:0]   r_out_data;
  logic                     r_out_valid;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;

  logic [PSUM_BW-1:0]       w_lane    [ROWS];
  logic [PSUM_BW-1:0]       w_aligned [ROWS];
  logic                     w_aligned_valid;
  logic [ACC_BW-1:0]        w_next    [ROWS];
  logic [ACC_BW-1:0]        w_first_row [ROWS];

  // --------------------------------------------------------------------------
  // Deskew: lane r is delayed ROWS-1-r cycles so every lane of a vector
  // arrives together with the delayed lane-0 valid. These run in all states.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    localparam int DLY = ROWS - 1 - r;
    assign w_lane[r] = bus.psum_in[r*PSUM_BW +: PSUM_BW];
    if (DLY == 0) begin : g_direct
      assign w_aligned[r] = w_lane[r];
    end else begin : g_delay
      logic [PSUM_BW-1:0] r_sr [DLY];
      // shift lane r through its DLY-stage delay line
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= w_lane[r];
          for (int i = 1; i < DLY; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign w_aligned[r] = r_sr[DLY-1];
    end
  end

  if (ROWS == 1) begin : g_vld_direct
    assign w_aligned_valid = bus.in_valid;
  end else begin : g_vld_delay
    logic r_vld_sr [ROWS-1];
    // delay lane-0 valid by ROWS-1 cycles to qualify the aligned vector
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < ROWS-1; i++) r_vld_sr[i] <= 1'b0;
      end else begin
        r_vld_sr[0] <= bus.in_valid;
        for (int i = 1; i < ROWS-1; i++) r_vld_sr[i] <= r_vld_sr[i-1];
      end
    end
    assign w_aligned_valid = r_vld_sr[ROWS-2];
  end

  // --------------------------------------------------------------------------
  // Per-lane next accumulator value: load on the first tile, add afterwards.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_sum
    logic [ACC_BW-1:0] w_ext;
    logic [ACC_BW-1:0] w_cur;
    logic [ACC_BW-1:0] w_add;
    assign w_ext = ACC_BW'($signed(w_aligned[r]));
    assign w_cur = r_acc[r_wr_ptr][r];
`ifdef SATURATE_EN
    logic [ACC_BW:0] w_wide;
    assign w_wide = {w_cur[ACC_BW-1], w_cur} + {w_ext[ACC_BW-1], w_ext};
    // clamp when the carry-out sign disagrees with the result sign
    always_comb begin
      w_add = w_wide[ACC_BW-1:0];
      if (w_wide[ACC_BW] != w_wide[ACC_BW-1]) begin
        w_add = w_wide[ACC_BW] ? c_ACC_MIN : c_ACC_MAX;
      end
    end
`else
    assign w_add = w_cur + w_ext;
`endif
    assign w_next[r] = (r_tile_idx == '0) ? w_ext : w_add;
    // row 0 may be the row being written on the final write when DEPTH==1
    assign w_first_row[r] = (r_wr_ptr == '0) ? w_next[r] : r_acc[0][r];
  end

  // --------------------------------------------------------------------------
  // Control FSM with accumulator bank, drain register and status outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tile_idx  <= '0;
      r_num_tiles <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
        for (int r = 0; r < ROWS; r++) r_acc[d][r] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_ACCUM;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tile_idx  <= '0;
            r_num_tiles <= (bus.num_tiles == '0) ? c_ONE_TILE : bus.num_tiles;
            r_busy      <= 1'b1;
            // a stray vector landing on the start cycle still flags
            r_err       <= w_aligned_valid;
          end else if (w_aligned_valid) begin
            r_err <= 1'b1;
          end
        end

        S_ACCUM: begin
          if (w_aligned_valid) begin
            for (int r = 0; r < ROWS; r++) r_acc[r_wr_ptr][r] <= w_next[r];
            if (r_wr_ptr == c_LAST_PTR) begin
              r_wr_ptr   <= '0;
              r_tile_idx <= r_tile_idx + c_ONE_TILE;
              if (r_tile_idx == r_num_tiles - c_ONE_TILE) begin
                r_state     <= S_DRAIN;
                r_rd_ptr    <= '0;
                r_out_valid <= 1'b1;
                for (int r = 0; r < ROWS; r++) begin
                  r_out_data[r*ACC_BW +: ACC_BW] <= w_first_row[r];
                end
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
          end
        end

        S_DRAIN: begin
          if (w_aligned_valid) r_err <= 1'b1;
          if (r_out_valid && bus.out_ready) begin
            if (r_rd_ptr == c_LAST_PTR) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
              for (int r = 0; r < ROWS; r++) begin
                r_out_data[r*ACC_BW +: ACC_BW] <= r_acc[r_rd_ptr + c_PTR_ONE][r];
              end
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule
`default_nettype wire
